// File: rtl/mic1_exec_ctrl.sv
// Execution controller for the MIC-1 core: turns front-panel command pulses into
// CPU clock-enable / synchronous reset, counts executed microinstructions, drives status LEDs.
module mic1_exec_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_run,
    input  logic             cmd_stop,
    input  logic             cmd_step,
    input  logic             cmd_reset,
    input  logic             cpu_cycle_done,
    input  logic             cpu_halt,
    output logic             cpu_clk_en,
    output logic             cpu_sync_reset,
    output logic [CNT_W-1:0] uinstr_count,
    output logic [2:0]       state,
    output logic [5:0]       led
);

    localparam logic [2:0] S_RESETTING = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_RUN       = 3'd2;
    localparam logic [2:0] S_STEP      = 3'd3;
    localparam logic [2:0] S_STOP_PEND = 3'd4;
    localparam logic [2:0] S_HALTED    = 3'd5;

    localparam logic [7:0]       RST_LOAD = 8'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic [7:0]       rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_en_q, clk_en_d;
    logic             sync_rst_q, sync_rst_d;
    logic [5:0]       led_q, led_d;

    // CPU completion strobes only count while the CPU is actually clocked.
    logic done, halt_done;
    assign done      = cpu_cycle_done & clk_en_q;
    assign halt_done = done & cpu_halt;

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cnt_d     = cnt_q;

        if (done && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (cmd_reset) begin
            state_d   = S_RESETTING;
            rst_cnt_d = RST_LOAD;
            cnt_d     = '0;
        end else begin
            case (state_q)
                S_RESETTING: begin
                    if (rst_cnt_q == 8'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        rst_cnt_d = rst_cnt_q - 8'd1;
                    end
                end
                S_IDLE: begin
                    if (cmd_step) begin
                        state_d = S_STEP;
                    end else if (cmd_run) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    // A stop landing on a boundary skips the pending state.
                    if (halt_done) begin
                        state_d = S_HALTED;
                    end else if (cmd_stop) begin
                        state_d = done ? S_IDLE : S_STOP_PEND;
                    end
                end
                S_STEP: begin
                    if (done) begin
                        state_d = halt_done ? S_HALTED : S_IDLE;
                    end
                end
                S_STOP_PEND: begin
                    if (done) begin
                        state_d = halt_done ? S_HALTED : S_IDLE;
                    end else if (cmd_run && !cmd_stop) begin
                        state_d = S_RUN;
                    end
                end
                S_HALTED: begin
                    state_d = S_HALTED;
                end
                default: begin
                    state_d   = S_RESETTING;
                    rst_cnt_d = RST_LOAD;
                end
            endcase
        end
    end

    always_comb begin
        clk_en_d   = (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_STOP_PEND);
        sync_rst_d = (state_d == S_RESETTING);
        led_d[0]   = (state_d == S_RUN) || (state_d == S_STOP_PEND);
        led_d[1]   = (state_d == S_IDLE) || (state_d == S_HALTED);
        led_d[2]   = (state_d == S_STEP);
        led_d[3]   = (state_d == S_STOP_PEND);
        led_d[4]   = (state_d == S_HALTED);
        led_d[5]   = (state_d == S_RESETTING);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_RESETTING;
            rst_cnt_q  <= RST_LOAD;
            cnt_q      <= '0;
            clk_en_q   <= 1'b0;
            sync_rst_q <= 1'b1;
            led_q      <= 6'b100000;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            cnt_q      <= cnt_d;
            clk_en_q   <= clk_en_d;
            sync_rst_q <= sync_rst_d;
            led_q      <= led_d;
        end
    end

    assign cpu_clk_en     = clk_en_q;
    assign cpu_sync_reset = sync_rst_q;
    assign uinstr_count   = cnt_q;
    assign state          = state_q;
    assign led            = led_q;

endmodule

// File: tb/tb_mic1_exec_ctrl.sv
// Self-checking bench for mic1_exec_ctrl: vector table, directed corner sequences and
// randomized commands checked against a cycle-level behavioural model.
module tb_mic1_exec_ctrl;

    localparam int RST_CYCLES = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, cmd_run, cmd_stop, cmd_step, cmd_reset, cpu_cycle_done, cpu_halt;
    logic        en16, sync16, en4, sync4;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;
    logic [2:0]  st16, st4;
    logic [5:0]  led16, led4;

    mic1_exec_ctrl #(.RST_CYCLES(RST_CYCLES), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .cmd_run(cmd_run), .cmd_stop(cmd_stop),
        .cmd_step(cmd_step), .cmd_reset(cmd_reset), .cpu_cycle_done(cpu_cycle_done),
        .cpu_halt(cpu_halt), .cpu_clk_en(en16), .cpu_sync_reset(sync16),
        .uinstr_count(cnt16), .state(st16), .led(led16)
    );

    mic1_exec_ctrl #(.RST_CYCLES(RST_CYCLES), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .cmd_run(cmd_run), .cmd_stop(cmd_stop),
        .cmd_step(cmd_step), .cmd_reset(cmd_reset), .cpu_cycle_done(cpu_cycle_done),
        .cpu_halt(cpu_halt), .cpu_clk_en(en4), .cpu_sync_reset(sync4),
        .uinstr_count(cnt4), .state(st4), .led(led4)
    );

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    // Behavioural model: named phase, cycles left in the reset window, plain integer counts.
    int m_state, m_rst_left, m_cnt16, m_cnt4;
    bit m_en;

    function automatic logic [5:0] led_of(int s);
        case (s)
            0: return 6'b100000;
            1: return 6'b000010;
            2: return 6'b000001;
            3: return 6'b000100;
            4: return 6'b001001;
            5: return 6'b010010;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic model_reset();
        m_state    = 0;
        m_rst_left = RST_CYCLES;
        m_cnt16    = 0;
        m_cnt4     = 0;
        m_en       = 1'b0;
    endtask

    task automatic model_update();
        bit d, h;
        int ns;
        d  = cpu_cycle_done && m_en;
        h  = d && cpu_halt;
        ns = m_state;
        if (cmd_reset) begin
            m_cnt16 = 0;
            m_cnt4  = 0;
        end else if (d) begin
            m_cnt16 = (m_cnt16 + 1 > 65535) ? 65535 : m_cnt16 + 1;
            m_cnt4  = (m_cnt4 + 1 > 15) ? 15 : m_cnt4 + 1;
        end
        if (cmd_reset) begin
            ns = 0;
            m_rst_left = RST_CYCLES;
        end else begin
            case (m_state)
                0: begin
                    m_rst_left--;
                    if (m_rst_left == 0) ns = 1;
                end
                1: if (cmd_step) ns = 3; else if (cmd_run) ns = 2;
                2: if (h) ns = 5; else if (cmd_stop) ns = d ? 1 : 4;
                3: if (d) ns = h ? 5 : 1;
                4: if (d) ns = h ? 5 : 1; else if (cmd_run && !cmd_stop) ns = 2;
                default: ns = m_state;
            endcase
        end
        m_state = ns;
        m_en    = (ns == 2) || (ns == 3) || (ns == 4);
        exp_q.push_back(m_cnt16[15:0]);
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [15:0] exp_cnt;
        exp_cnt = exp_q.pop_front();
        chk("state", int'(st16), m_state);
        chk("state_w4", int'(st4), m_state);
        chk("clk_en", int'(en16), int'(m_en));
        chk("sync_reset", int'(sync16), int'(m_state == 0));
        chk("led", int'(led16), int'(led_of(m_state)));
        chk("count", int'(cnt16), int'(exp_cnt));
        chk("count_w4", int'(cnt4), m_cnt4);
    endtask

    task automatic apply(bit run, bit stop, bit step, bit rst, bit done, bit halt);
        cmd_run = run; cmd_stop = stop; cmd_step = step; cmd_reset = rst;
        cpu_cycle_done = done; cpu_halt = halt;
        @(posedge clk);
        model_update();
        #1;
        compare_model();
        cmd_run = 0; cmd_stop = 0; cmd_step = 0; cmd_reset = 0;
        cpu_cycle_done = 0; cpu_halt = 0;
    endtask

    task automatic async_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_state", int'(st16), 0);
        chk("async_led", int'(led16), 32);
        chk("async_sync", int'(sync16), 1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit run, stop, step, rst, done, halt;
        logic [2:0] st;
        bit en, sync;
        logic [5:0] led;
        int cnt;
    } vec_t;
    vec_t vecs[27];

    initial begin
        reset = 0; cmd_run = 0; cmd_stop = 0; cmd_step = 0; cmd_reset = 0;
        cpu_cycle_done = 0; cpu_halt = 0;

        // run stop step rst done halt | state en sync led cnt
        vecs[0]  = '{0,0,0,0,0,0, 3'd0, 0,1, 6'b100000, 0};
        vecs[1]  = '{0,0,0,0,0,0, 3'd0, 0,1, 6'b100000, 0};
        vecs[2]  = '{0,0,0,0,0,0, 3'd0, 0,1, 6'b100000, 0};
        vecs[3]  = '{0,0,0,0,0,0, 3'd1, 0,0, 6'b000010, 0};
        vecs[4]  = '{1,0,0,0,0,0, 3'd2, 1,0, 6'b000001, 0};
        vecs[5]  = '{0,0,0,0,1,0, 3'd2, 1,0, 6'b000001, 1};
        vecs[6]  = '{0,1,0,0,0,0, 3'd4, 1,0, 6'b001001, 1};
        vecs[7]  = '{0,0,0,0,0,0, 3'd4, 1,0, 6'b001001, 1};
        vecs[8]  = '{1,0,0,0,0,0, 3'd2, 1,0, 6'b000001, 1};
        vecs[9]  = '{0,1,0,0,1,0, 3'd1, 0,0, 6'b000010, 2};
        vecs[10] = '{0,0,1,0,0,0, 3'd3, 1,0, 6'b000100, 2};
        vecs[11] = '{0,0,1,0,0,0, 3'd3, 1,0, 6'b000100, 2};
        vecs[12] = '{0,0,0,0,1,0, 3'd1, 0,0, 6'b000010, 3};
        vecs[13] = '{0,0,0,0,1,0, 3'd1, 0,0, 6'b000010, 3};
        vecs[14] = '{0,1,0,0,0,0, 3'd1, 0,0, 6'b000010, 3};
        vecs[15] = '{1,0,0,0,0,0, 3'd2, 1,0, 6'b000001, 3};
        vecs[16] = '{0,0,0,0,1,1, 3'd5, 0,0, 6'b010010, 4};
        vecs[17] = '{1,0,0,0,0,0, 3'd5, 0,0, 6'b010010, 4};
        vecs[18] = '{0,0,1,0,0,0, 3'd5, 0,0, 6'b010010, 4};
        vecs[19] = '{0,0,0,0,1,1, 3'd5, 0,0, 6'b010010, 4};
        vecs[20] = '{0,0,0,1,0,0, 3'd0, 0,1, 6'b100000, 0};
        vecs[21] = '{0,0,0,0,0,0, 3'd0, 0,1, 6'b100000, 0};
        vecs[22] = '{0,0,0,1,0,0, 3'd0, 0,1, 6'b100000, 0};
        vecs[23] = '{0,0,0,0,0,0, 3'd0, 0,1, 6'b100000, 0};
        vecs[24] = '{0,0,0,0,0,0, 3'd0, 0,1, 6'b100000, 0};
        vecs[25] = '{0,0,0,0,0,0, 3'd0, 0,1, 6'b100000, 0};
        vecs[26] = '{0,0,0,0,0,0, 3'd1, 0,0, 6'b000010, 0};

        async_reset();

        for (int i = 0; i < 27; i++) begin
            apply(vecs[i].run, vecs[i].stop, vecs[i].step, vecs[i].rst, vecs[i].done, vecs[i].halt);
            chk($sformatf("vec%0d_state", i), int'(st16), int'(vecs[i].st));
            chk($sformatf("vec%0d_en", i), int'(en16), int'(vecs[i].en));
            chk($sformatf("vec%0d_sync", i), int'(sync16), int'(vecs[i].sync));
            chk($sformatf("vec%0d_led", i), int'(led16), int'(vecs[i].led));
            chk($sformatf("vec%0d_cnt", i), int'(cnt16), vecs[i].cnt);
        end

        // Run for ten microinstructions, stop, wait at the boundary, then finish it.
        apply(1,0,0,0,0,0);
        repeat (10) apply(0,0,0,0,1,0);
        apply(0,1,0,0,0,0);
        chk("seq_stop_pend", int'(st16), 4);
        repeat (3) apply(0,0,0,0,0,0);
        chk("seq_en_while_pend", int'(en16), 1);
        apply(0,0,0,0,1,0);
        chk("seq_idle", int'(st16), 1);
        chk("seq_en_dropped", int'(en16), 0);
        chk("seq_count11", int'(cnt16), 11);

        // Saturation on the narrow counter.
        apply(1,0,0,0,0,0);
        repeat (20) apply(0,0,0,0,1,0);
        chk("sat_w4", int'(cnt4), 15);
        chk("nosat_w16", int'(cnt16), 31);
        apply(0,1,0,0,1,0);
        chk("stop_on_boundary", int'(st16), 1);

        // Stop beats run; run from STOP_PEND cancels without dropping the enable.
        apply(1,0,0,0,0,0);
        apply(1,1,0,0,0,0);
        chk("stop_beats_run", int'(st16), 4);
        apply(1,0,0,0,0,0);
        chk("cancel_stop", int'(st16), 2);
        chk("cancel_stop_en", int'(en16), 1);
        apply(0,0,0,1,0,0);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end
            apply($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
